// File: rtl/mem_addr_fu_if.sv
// Issue / completion bus of the memory-address unit.
// valid/ready: a push happens on a rising edge where in_valid && in_ready; a pop on an edge where sel && out_valid.
interface mem_addr_fu_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4,
  parameter int ROB_W = 5,
  parameter int PRF_W = 6
);
  logic                       in_valid;
  logic [XLEN-1:0]            in_op1;
  logic [XLEN-1:0]            in_op2;
  logic [XLEN-1:0]            in_pc;
  logic [ROB_W-1:0]           in_rob_entry;
  logic [PRF_W-1:0]           in_dest_prf;
  logic [4:0]                 in_dest_arf;
  logic                       in_is_store;
  logic [1:0]                 in_size;
  logic                       in_ready;
  logic                       sel;
  logic                       squash;
  logic                       out_valid;
  logic [XLEN-1:0]            out_addr;
  logic [XLEN/8-1:0]          out_byte_en;
  logic                       out_misaligned;
  logic                       out_is_store;
  logic [ROB_W-1:0]           out_rob_entry;
  logic [PRF_W-1:0]           out_dest_prf;
  logic                       out_value_valid;
  logic [XLEN-1:0]            out_branch_address;
  logic [$clog2(DEPTH):0]     count;

  modport master (
    output in_valid, in_op1, in_op2, in_pc, in_rob_entry, in_dest_prf, in_dest_arf,
           in_is_store, in_size, sel, squash,
    input  in_ready, out_valid, out_addr, out_byte_en, out_misaligned, out_is_store,
           out_rob_entry, out_dest_prf, out_value_valid, out_branch_address, count
  );

  modport slave (
    input  in_valid, in_op1, in_op2, in_pc, in_rob_entry, in_dest_prf, in_dest_arf,
           in_is_store, in_size, sel, squash,
    output in_ready, out_valid, out_addr, out_byte_en, out_misaligned, out_is_store,
           out_rob_entry, out_dest_prf, out_value_valid, out_branch_address, count
  );
endinterface

// File: rtl/mem_addr_fu.sv
// Memory-address functional unit: computes address, byte enables and misalignment at issue,
// then holds results in an in-order buffer until the completion arbiter pops them.
module mem_addr_fu #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4,
  parameter int ROB_W = 5,
  parameter int PRF_W = 6
) (
  input  logic          clk,
  input  logic          rst,
  mem_addr_fu_if.slave  bus
);
  localparam int BE_W   = XLEN / 8;
  localparam int OFF_W  = $clog2(BE_W);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int LANE_W = 2 * BE_W;

  typedef struct packed {
    logic [XLEN-1:0]  addr;
    logic [BE_W-1:0]  be;
    logic             mis;
    logic             st;
    logic [ROB_W-1:0] rob;
    logic [PRF_W-1:0] prf;
    logic             vv;
    logic [XLEN-1:0]  ba;
  } entry_t;

  entry_t           r_mem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;

  logic              w_push;
  logic              w_pop;
  logic [XLEN-1:0]   w_addr;
  logic [3:0]        w_nbytes;
  logic [2:0]        w_align_mask;
  logic              w_size_illegal;
  logic              w_unaligned;
  logic              w_mis;
  logic [LANE_W-1:0] w_lanes;
  logic [LANE_W-1:0] w_be_wide;
  logic [OFF_W-1:0]  w_offset;
  entry_t            w_entry;
  entry_t            w_head;

  // in_ready depends on registered occupancy only; a same-cycle pop never frees a slot early.
  assign bus.in_ready = (r_count < CNT_W'(DEPTH));
  assign bus.out_valid = (r_count != '0);
  assign w_push = bus.in_valid && bus.in_ready;
  assign w_pop  = bus.sel && bus.out_valid;

  assign w_addr         = bus.in_op1 + bus.in_op2;
  assign w_nbytes       = 4'd1 << bus.in_size;
  assign w_align_mask   = 3'(w_nbytes - 4'd1);
  assign w_size_illegal = int'(w_nbytes) > BE_W;
  assign w_unaligned    = |(w_addr[2:0] & w_align_mask);
  assign w_mis          = w_size_illegal || w_unaligned;
  assign w_offset       = w_addr[OFF_W-1:0];

  always_comb begin
    w_lanes = '0;
    case (bus.in_size)
      2'd0:    w_lanes = LANE_W'(8'h01);
      2'd1:    w_lanes = LANE_W'(8'h03);
      2'd2:    w_lanes = LANE_W'(8'h0F);
      default: w_lanes = LANE_W'(8'hFF);
    endcase
  end

  assign w_be_wide = w_lanes << w_offset;

  always_comb begin
    w_entry      = '0;
    w_entry.addr = w_addr;
    w_entry.be   = w_mis ? '0 : w_be_wide[BE_W-1:0];
    w_entry.mis  = w_mis;
    w_entry.st   = bus.in_is_store;
    w_entry.rob  = bus.in_rob_entry;
    w_entry.prf  = bus.in_dest_prf;
    w_entry.vv   = (bus.in_dest_arf != 5'd0) && !bus.in_is_store;
    w_entry.ba   = bus.in_pc + XLEN'(4);
  end

  // Storage is not reset; out_valid gates visibility of stale entries.
  always_ff @(posedge clk) begin
    if (w_push && !bus.squash) begin
      r_mem[r_tail] <= w_entry;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (bus.squash) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + PTR_W'(1);
      if (w_pop)  r_head <= r_head + PTR_W'(1);
      if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
      else if (!w_push && w_pop) r_count <= r_count - CNT_W'(1);
    end
  end

  assign w_head                 = r_mem[r_head];
  assign bus.out_addr           = w_head.addr;
  assign bus.out_byte_en        = w_head.be;
  assign bus.out_misaligned     = w_head.mis;
  assign bus.out_is_store       = w_head.st;
  assign bus.out_rob_entry      = w_head.rob;
  assign bus.out_dest_prf       = w_head.prf;
  assign bus.out_value_valid    = w_head.vv;
  assign bus.out_branch_address = w_head.ba;
  assign bus.count              = r_count;
endmodule

// File: tb/tb_mem_addr_fu.sv
// Bench for mem_addr_fu: directed scenarios with literal expectations plus random traffic
// compared every cycle against a queue-based reference model.
module tb_mem_addr_fu;
  localparam int XLEN  = 32;
  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    bit          mis;
    bit          st;
    logic [4:0]  rob;
    logic [5:0]  prf;
    bit          vv;
    logic [31:0] ba;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  exp_t exp_q[$];

  mem_addr_fu_if #(.XLEN(XLEN), .DEPTH(DEPTH), .ROB_W(5), .PRF_W(6)) bus ();

  mem_addr_fu #(.XLEN(XLEN), .DEPTH(DEPTH), .ROB_W(5), .PRF_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: what an accepted op must produce, from the address rules
  function automatic exp_t model_op();
    exp_t e;
    int   nbytes;
    nbytes = 1 << bus.in_size;
    e.addr = bus.in_op1 + bus.in_op2;
    e.mis  = (nbytes > XLEN / 8) || ((e.addr % nbytes) != 0);
    e.be   = e.mis ? 4'd0 : 4'(((1 << nbytes) - 1) << (e.addr % (XLEN / 8)));
    e.st   = bus.in_is_store;
    e.rob  = bus.in_rob_entry;
    e.prf  = bus.in_dest_prf;
    e.vv   = (bus.in_dest_arf != 0) && !bus.in_is_store;
    e.ba   = bus.in_pc + 32'd4;
    return e;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
    end else if (bus.squash) begin
      exp_q.delete();
    end else begin
      bit do_pop;
      bit do_push;
      exp_t e;
      do_pop  = bus.sel && (exp_q.size() > 0);
      do_push = bus.in_valid && (exp_q.size() < DEPTH);
      e = model_op();
      if (do_pop) void'(exp_q.pop_front());
      if (do_push) exp_q.push_back(e);
    end
  end

  // scoreboard compare, every cycle out of reset
  always @(negedge clk) begin
    if (!rst) begin
      chk("out_valid", 64'(bus.out_valid), 64'(exp_q.size() > 0));
      chk("count", 64'(bus.count), 64'(exp_q.size()));
      chk("in_ready", 64'(bus.in_ready), 64'(exp_q.size() < DEPTH));
      if (exp_q.size() > 0) begin
        chk("out_addr", 64'(bus.out_addr), 64'(exp_q[0].addr));
        chk("out_byte_en", 64'(bus.out_byte_en), 64'(exp_q[0].be));
        chk("out_misaligned", 64'(bus.out_misaligned), 64'(exp_q[0].mis));
        chk("out_is_store", 64'(bus.out_is_store), 64'(exp_q[0].st));
        chk("out_rob_entry", 64'(bus.out_rob_entry), 64'(exp_q[0].rob));
        chk("out_dest_prf", 64'(bus.out_dest_prf), 64'(exp_q[0].prf));
        chk("out_value_valid", 64'(bus.out_value_valid), 64'(exp_q[0].vv));
        chk("out_branch_address", 64'(bus.out_branch_address), 64'(exp_q[0].ba));
      end
    end
  end

  // driver tasks
  task automatic idle();
    bus.in_valid     = 1'b0;
    bus.in_op1       = '0;
    bus.in_op2       = '0;
    bus.in_pc        = '0;
    bus.in_rob_entry = '0;
    bus.in_dest_prf  = '0;
    bus.in_dest_arf  = '0;
    bus.in_is_store  = 1'b0;
    bus.in_size      = 2'd0;
    bus.sel          = 1'b0;
    bus.squash       = 1'b0;
  endtask

  task automatic set_op(input logic [31:0] op1, input logic [31:0] op2, input logic [1:0] size,
                        input bit st, input logic [4:0] rob, input logic [4:0] arf);
    bus.in_valid     = 1'b1;
    bus.in_op1       = op1;
    bus.in_op2       = op2;
    bus.in_size      = size;
    bus.in_is_store  = st;
    bus.in_rob_entry = rob;
    bus.in_dest_arf  = arf;
    bus.in_dest_prf  = 6'(rob) + 6'd7;
    bus.in_pc        = op1 ^ 32'h0000_4000;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    idle();
    bus.sel = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) step();
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    checks = 0;
    errors = 0;
    idle();
    rst = 1'b1;
    #2;
    chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
    chk("reset_count", 64'(bus.count), 64'd0);
    chk("reset_in_ready", 64'(bus.in_ready), 64'd1);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    step();

    // aligned word load
    set_op(32'h1000, 32'h4, 2'd2, 1'b0, 5'd1, 5'd5);
    step();
    idle();
    chk("ld_valid", 64'(bus.out_valid), 64'd1);
    chk("ld_addr", 64'(bus.out_addr), 64'h1004);
    chk("ld_be", 64'(bus.out_byte_en), 64'hF);
    chk("ld_mis", 64'(bus.out_misaligned), 64'd0);
    chk("ld_vv", 64'(bus.out_value_valid), 64'd1);
    chk("ld_count", 64'(bus.count), 64'd1);
    chk("ld_ba", 64'(bus.out_branch_address), 64'h5004);
    drain();

    // byte store at lane 3
    set_op(32'h2003, 32'h0, 2'd0, 1'b1, 5'd2, 5'd9);
    step();
    idle();
    chk("sb_be", 64'(bus.out_byte_en), 64'h8);
    chk("sb_vv", 64'(bus.out_value_valid), 64'd0);
    chk("sb_store", 64'(bus.out_is_store), 64'd1);
    drain();

    // misaligned half, illegal doubleword, load to x0
    set_op(32'h2001, 32'h0, 2'd1, 1'b0, 5'd3, 5'd4);
    step();
    idle();
    chk("lh_mis", 64'(bus.out_misaligned), 64'd1);
    chk("lh_be", 64'(bus.out_byte_en), 64'h0);
    drain();
    set_op(32'h3000, 32'h8, 2'd3, 1'b0, 5'd4, 5'd0);
    step();
    idle();
    chk("ld64_mis", 64'(bus.out_misaligned), 64'd1);
    chk("ld64_be", 64'(bus.out_byte_en), 64'h0);
    chk("x0_vv", 64'(bus.out_value_valid), 64'd0);
    drain();

    // fill, overflow push ignored
    for (int i = 0; i < DEPTH; i++) begin
      set_op(32'h100 * i, 32'h2, 2'd1, 1'b0, 5'(10 + i), 5'd1);
      step();
    end
    chk("full_ready", 64'(bus.in_ready), 64'd0);
    set_op(32'h0, 32'h0, 2'd0, 1'b0, 5'd14, 5'd1);
    step();
    chk("full_count", 64'(bus.count), 64'd4);
    chk("full_head", 64'(bus.out_rob_entry), 64'd10);

    // simultaneous push/pop across pointer wrap
    for (int i = 0; i < 8; i++) begin
      set_op($urandom, 32'h0, 2'd0, 1'b1, 5'(20 + i), 5'd0);
      bus.sel = 1'b1;
      step();
      chk("wrap_count_bound", 64'(bus.count <= 4), 64'd1);
    end
    drain();

    // push+pop at count=2
    set_op(32'h40, 32'h0, 2'd2, 1'b0, 5'd5, 5'd3);
    step();
    set_op(32'h44, 32'h0, 2'd2, 1'b0, 5'd6, 5'd3);
    step();
    set_op(32'h48, 32'h0, 2'd2, 1'b0, 5'd7, 5'd3);
    bus.sel = 1'b1;
    step();
    idle();
    chk("pp_count", 64'(bus.count), 64'd2);
    chk("pp_head", 64'(bus.out_rob_entry), 64'd6);
    drain();

    // squash with concurrent push and pop
    for (int i = 0; i < 3; i++) begin
      set_op(32'h80, 32'(4 * i), 2'd2, 1'b0, 5'(16 + i), 5'd2);
      step();
    end
    set_op(32'h90, 32'h0, 2'd2, 1'b0, 5'd19, 5'd2);
    bus.sel    = 1'b1;
    bus.squash = 1'b1;
    step();
    idle();
    chk("sq_count", 64'(bus.count), 64'd0);
    chk("sq_valid", 64'(bus.out_valid), 64'd0);
    set_op(32'hA0, 32'h0, 2'd2, 1'b0, 5'd30, 5'd2);
    step();
    idle();
    chk("sq_next_head", 64'(bus.out_rob_entry), 64'd30);
    chk("sq_next_count", 64'(bus.count), 64'd1);
    drain();

    // asynchronous reset between edges
    for (int i = 0; i < 3; i++) begin
      set_op(32'hC0, 32'(4 * i), 2'd2, 1'b0, 5'(8 + i), 5'd2);
      step();
    end
    idle();
    #1 rst = 1'b1;
    #1;
    chk("arst_valid", 64'(bus.out_valid), 64'd0);
    chk("arst_ready", 64'(bus.in_ready), 64'd1);
    chk("arst_count", 64'(bus.count), 64'd0);
    step();
    #2 rst = 1'b0;
    set_op(32'hD0, 32'h0, 2'd2, 1'b0, 5'd12, 5'd2);
    step();
    idle();
    chk("arst_first_push", 64'(bus.out_rob_entry), 64'd12);
    drain();

    // random traffic
    for (int i = 0; i < 400; i++) begin
      idle();
      if ($urandom_range(0, 3) != 0)
        set_op($urandom, 32'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
               bit'($urandom_range(0, 1)), 5'($urandom), 5'($urandom_range(0, 3)));
      bus.sel    = ($urandom_range(0, 2) == 0);
      bus.squash = ($urandom_range(0, 40) == 0);
      step();
    end
    idle();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
